// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : IF->ID instruction queue (pc, instr) with valid/ready handshake
//               and flush on redirect. Optional combinational fall-through into
//               an empty queue when IF_ID_QUEUE_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic [63:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic        w_empty;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;
    logic [63:0] w_head;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != c_full);
    assign count    = r_count;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // An entry that falls straight through to a ready consumer is never stored
    assign w_push    = in_valid & in_ready & ~flush & ~(w_bypass & out_ready);
    assign w_pop     = ~w_empty & out_ready & ~flush;
    assign out_valid = ~w_empty | w_bypass;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        out_pc    = 32'h0;
        out_instr = 32'h0;
        if (!w_empty) begin
            out_pc    = w_head[63:32];
            out_instr = w_head[31:0];
        end else if (w_bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Scoreboard bench for if_id_queue (ordering, full, wrap, flush,
//               bypass, asynchronous reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [31:0]   in_pc     = 32'h0;
    logic [31:0]   in_instr  = 32'h0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    int          checks = 0;
    int          errors = 0;
    int          mcount = 0;
    logic [63:0] sb [$];

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic bit exp_bypass();
        return BYP && (mcount == 0) && in_valid && !flush;
    endfunction

    function automatic bit exp_valid();
        return (mcount != 0) || exp_bypass();
    endfunction

    function automatic logic [63:0] exp_head();
        if (mcount != 0) return sb[0];
        if (exp_bypass()) return {in_pc, in_instr};
        return 64'h0;
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit rdy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Advances one edge and applies the reference behaviour to the scoreboard
    task automatic tick();
        bit          p, q, byp, fl;
        logic [63:0] d;
        byp = exp_bypass();
        fl  = flush;
        d   = {in_pc, in_instr};
        q   = (mcount != 0) && out_ready && !flush;
        p   = in_valid && (mcount != DEPTH) && !flush && !(byp && out_ready);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (q) sb.delete(0);
            if (p) sb.push_back(d);
        end
        mcount = sb.size();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
        checks++; if (count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_after_rst: count %0d valid %b ready %b want 0 0 1", count, out_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_ordering();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h60, 32'h64, 32'h68};
        ins = '{32'h11111111, 32'h22222222, 32'h33333333};
        for (int i = 0; i < 3; i++) begin
            drive(1, pcs[i], ins[i], 0, 0);
            tick();
        end
        drive(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL ord_count: got %0d want 3", count); end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ord_valid%0d: got %b want 1", i, out_valid); end
            checks++; if ({out_pc, out_instr} !== exp_head()) begin
                errors++; $display("FAIL ord_head%0d: got %h_%h want %h", i, out_pc, out_instr, exp_head());
            end
            tick();
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || count !== '0) begin
            errors++; $display("FAIL ord_empty: valid %b count %0d want 0 0", out_valid, count);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h80 + 32'(4 * i), 32'hA0000000 + 32'(i), 0, 0);
            tick();
        end
        drive(1, 32'h70, 32'h55555555, 0, 0);
        @(negedge clk);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
        tick();
        drive(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_freed: got %b want 1", in_ready); end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== exp_valid() || (exp_valid() && {out_pc, out_instr} !== exp_head())) begin
                errors++; $display("FAIL full_drain%0d: got %b %h_%h want %b %h", i, out_valid, out_pc, out_instr, exp_valid(), exp_head());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h200 + 32'(4 * i), 32'hB0000000 + 32'(i), 0, 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h300 + 32'(4 * i), 32'hC0000000 + 32'(i), 1, 0);
            @(negedge clk);
            checks++; if (count !== CW'(2)) begin errors++; $display("FAIL b2b_count%0d: got %0d want 2", i, count); end
            checks++; if ({out_pc, out_instr} !== exp_head()) begin
                errors++; $display("FAIL b2b_head%0d: got %h_%h want %h", i, out_pc, out_instr, exp_head());
            end
            tick();
        end
        drive(0, 32'h0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== exp_valid() || (exp_valid() && {out_pc, out_instr} !== exp_head())) begin
                errors++; $display("FAIL b2b_drain%0d: got %b %h_%h want %b %h", i, out_valid, out_pc, out_instr, exp_valid(), exp_head());
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h400 + 32'(4 * i), 32'hD0000000 + 32'(i), 0, 0);
            tick();
        end
        drive(1, 32'h500, 32'h99999999, 1, 1);
        @(negedge clk);
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL fl_pre_count: got %0d want 3", count); end
        tick();
        drive(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        checks++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL fl_after: count %0d valid %b ready %b want 0 0 1", count, out_valid, in_ready);
        end
        tick();
        drive(1, 32'hAABBCCDC, 32'h44444444, 0, 0);
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || {out_pc, out_instr} !== {32'hAABBCCDC, 32'h44444444}) begin
            errors++; $display("FAIL fl_new_head: got %b %h_%h want 1 aabbccdc_44444444", out_valid, out_pc, out_instr);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1, 32'h64, 32'h11111111, 1, 0);
        @(negedge clk);
        checks++; if (out_valid !== BYP) begin errors++; $display("FAIL byp_valid: got %b want %b", out_valid, BYP); end
        if (BYP) begin
            checks++; if ({out_pc, out_instr} !== {32'h64, 32'h11111111}) begin
                errors++; $display("FAIL byp_data: got %h_%h want 00000064_11111111", out_pc, out_instr);
            end
        end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        checks++; if (count !== (BYP ? CW'(0) : CW'(1))) begin errors++; $display("FAIL byp_count: got %0d want %0d", count, BYP ? 0 : 1); end
        checks++; if (out_valid !== !BYP) begin errors++; $display("FAIL byp_next_valid: got %b want %b", out_valid, !BYP); end
        if (!BYP) begin
            checks++; if ({out_pc, out_instr} !== {32'h64, 32'h11111111}) begin
                errors++; $display("FAIL byp_next_data: got %h_%h want 00000064_11111111", out_pc, out_instr);
            end
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h600 + 32'(4 * i), 32'hE0000000 + 32'(i), 0, 0);
            tick();
        end
        drive(0, 32'h0, 32'h0, 0, 0);
        #2 rst = 1'b0;
        #1;
        checks++; if (count !== '0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL arst: count %0d valid %b pc %h want 0 0 0", count, out_valid, out_pc);
        end
        sb.delete();
        mcount = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1, 32'h700, 32'hF0F0F0F0, 0, 0);
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        checks++; if (count !== CW'(1) || {out_pc, out_instr} !== {32'h700, 32'hF0F0F0F0}) begin
            errors++; $display("FAIL arst_resume: count %0d head %h_%h want 1 00000700_f0f0f0f0", count, out_pc, out_instr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_full();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the IF stage and the ID stage of the rv32i pipeline.
- Buffers fetched (pc, instruction) pairs from IF's output packet so that I-cache fetch continues while decode is stalled.
- Discards all buffered entries on a control-flow redirect (flush), which happens when IF reloads the PC from alu_out or alu_mod2.
- Presents the oldest entry to ID under a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries; power of two, 2 to 16.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low; asserted when 0.
- flush  input  1  synchronous discard of all entries (redirect from control).
- in_valid  input  1  IF presents a fetched instruction.
- in_pc  input  32  PC of the fetched instruction (if_out.data.pc).
- in_instr  input  32  fetched instruction word (if_out.data.instruction).
- in_ready  output  1  queue accepts a push this cycle.
- out_valid  output  1  head entry is valid for ID.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction word of the head entry.
- out_ready  input  1  ID consumes the head entry this cycle.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array (pc, instr), write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each), and count.
- Pointers wrap modulo DEPTH with natural overflow.
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs during reset: in_ready=1, out_valid=0, out_pc=0, out_instr=0.
  - Storage array is not reset.
- in_ready = (count != DEPTH). It is purely state-based, with no combinational path from out_ready or in_valid.
- out_valid = (count != 0).
- out_pc and out_instr = head entry when out_valid=1, and forced to 32'h0 when the queue is empty.
- push = in_valid & in_ready & ~flush. Write at the rising edge to mem[wr_ptr], then wr_ptr+1.
- pop = out_valid & out_ready & ~flush. At the rising edge, rd_ptr+1.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (out_valid=1 in cycle N+1). There is no same-cycle fall-through unless the optional feature is enabled.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored. A pop in the same cycle frees the slot for the next cycle only.
- Empty (count=0): out_ready is ignored and no pop occurs.
- Flush:
  - At the next edge: wr_ptr=rd_ptr=0 and count=0.
  - Flush has priority over a simultaneous push and pop; both are dropped.
  - In the cycle after flush: out_valid=0 and in_ready=1.
- in_valid held with in_ready=0 leaves the data at IF; the queue never samples it.
- Order: strict FIFO. ID receives entries in push order with no duplication or loss except by flush.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Operation resumes on the first edge after rst returns to 1.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- With the macro defined, when count=0 and in_valid=1 and flush=0:
  - out_valid=1, out_pc=in_pc, out_instr=in_instr in the same cycle (combinational fall-through).
  - If out_ready=1, the entry is consumed directly: not written, pointers and count unchanged.
  - If out_ready=0, the entry is written normally.
  - in_ready is unchanged (still state-based).
- With the macro undefined, the queue always adds one cycle of latency as described in Behaviour.

Test Plan:
- Reset: hold rst=0 for 5 cycles -> in_ready=1, out_valid=0, out_pc=0, out_instr=0, count=0. Release, hold in_valid=0 -> state unchanged.
- Ordering: push (0x60,0x11111111), (0x64,0x22222222), (0x68,0x33333333) with out_ready=0 -> count=3. Then out_ready=1 -> pops 0x60, 0x64, 0x68 in order, then out_valid=0 and count=0.
- Full: push 4 entries with DEPTH=4 and out_ready=0 -> count=4, in_ready=0. A 5th push (0x70,0x55555555) is not stored. One pop -> in_ready=1 next cycle.
- Simultaneous push/pop: at count=2, push and pop in the same cycle for 6 cycles (pointers wrap) -> count stays 2 and output order matches input order.
- Flush: at count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. The next pushed entry (0xAABBCCDC,0x44444444) appears as head.
- Bypass (IF_ID_QUEUE_BYPASS_EN): empty queue, in_valid=1 (0x64,0x11111111), out_ready=1 -> out_valid=1 with the same values in the same cycle, and count stays 0. Without the macro, out_valid=1 only in the next cycle.
